// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the direct-mapped instruction cache
// Tags are stored zero-extended to the widest tag (NFRAMES=2) so one frame type fits all sizes.
package cpu_types_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  localparam int ICACHE_MAX_TAGW = 29;

  typedef struct packed {
    logic                       valid;
    logic [ICACHE_MAX_TAGW-1:0] tag;
    logic [31:0]                data;
  } icache_frame_t;

  // Address split for the default 16-frame configuration.
  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with single-word miss fill
// Optional hit/miss counters under ICACHE_STATS_EN.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic [31:0] iload,
  input  logic        iwait
);

  localparam int IDXW = $clog2(NFRAMES);

  icache_state_t             state_q, state_d;
  logic [29:0]               fetch_addr_q, fetch_addr_d;
  icache_frame_t             frame_q [NFRAMES];
  logic                      fill_en;

  logic [IDXW-1:0]           req_idx;
  logic [ICACHE_MAX_TAGW-1:0] req_tag;
  logic [IDXW-1:0]           fetch_idx;
  logic [ICACHE_MAX_TAGW-1:0] fetch_tag;
  logic                      hit;
  logic                      unused_bytoff;

  assign unused_bytoff = ^imemaddr[1:0];

  assign req_idx   = imemaddr[IDXW+1:2];
  assign req_tag   = ICACHE_MAX_TAGW'(imemaddr[31:IDXW+2]);
  assign fetch_idx = fetch_addr_q[IDXW-1:0];
  assign fetch_tag = ICACHE_MAX_TAGW'(fetch_addr_q[29:IDXW]);

  // No bypass of fill data: hits are only reported from the array while idle.
  assign hit = imemREN && (state_q == IDLE) && frame_q[req_idx].valid
               && (frame_q[req_idx].tag == req_tag);

  assign ihit     = hit;
  assign imemload = hit ? frame_q[req_idx].data : 32'h0;
  assign iREN     = (state_q == FETCH);
  assign iaddr    = (state_q == FETCH) ? {fetch_addr_q, 2'b00} : 32'h0;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    fill_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          state_d      = FETCH;
          fetch_addr_d = imemaddr[31:2];
        end
      end
      FETCH: begin
        if (!iwait) begin
          state_d = IDLE;
          fill_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        frame_q[i].valid <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      if (fill_en) begin
        frame_q[fetch_idx] <= '{valid: 1'b1, tag: fetch_tag, data: iload};
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit) hit_count_q <= hit_count_q + 32'd1;
      if ((state_q == IDLE) && (state_d == FETCH)) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard bench for icache_direct (ICACHE_STATS_EN also checks counters)
module tb_icache_direct;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic        hit;
    logic [31:0] load;
    logic        ren;
    logic [31:0] addr;
  } resp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload = 32'h0;
  logic        iwait = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_direct #(.NFRAMES(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .iload(iload), .iwait(iwait)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  resp_t expq[$];

  // Reference cache: what a 16-entry direct-mapped store holds after each completed fill.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];

  localparam resp_t IDLE_RESP = '{hit: 1'b0, load: 32'h0, ren: 1'b0, addr: 32'h0};

  function automatic resp_t fetch_resp(input logic [31:0] a);
    return '{hit: 1'b0, load: 32'h0, ren: 1'b1, addr: {a[31:2], 2'b00}};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    icachef_t f;
    f = a;
    return m_valid[f.idx] && (m_tag[f.idx] == f.tag);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic drive(input logic rst, input logic req, input logic [31:0] a,
                       input logic w, input logic [31:0] ld, input resp_t e);
    @(posedge CLK);
    #1;
    RST = rst; imemREN = req; imemaddr = a; iwait = w; iload = ld;
    expq.push_back(e);
    if (rst) begin
      exp_hits = 0;
      exp_misses = 0;
    end else if (e.hit) begin
      exp_hits++;
    end
  endtask

  // One full instruction fetch: immediate hit, or miss + n busy cycles + fill + hit.
  task automatic access(input logic [31:0] a, input int n, input logic [31:0] data);
    icachef_t f;
    f = a;
    if (m_hit(a)) begin
      drive(1'b0, 1'b1, a, 1'($urandom), $urandom, '{hit: 1'b1, load: m_data[f.idx], ren: 1'b0, addr: 32'h0});
    end else begin
      drive(1'b0, 1'b1, a, 1'($urandom), $urandom, IDLE_RESP);
      exp_misses++;
      for (int i = 0; i < n; i++)
        drive(1'b0, 1'($urandom), $urandom, 1'b1, $urandom, fetch_resp(a));
      drive(1'b0, 1'($urandom), $urandom, 1'b0, data, fetch_resp(a));
      m_valid[f.idx] = 1'b1;
      m_tag[f.idx]   = f.tag;
      m_data[f.idx]  = data;
      drive(1'b0, 1'b1, a, 1'($urandom), $urandom, '{hit: 1'b1, load: data, ren: 1'b0, addr: 32'h0});
    end
  endtask

  task automatic check_stats(input string name);
`ifdef ICACHE_STATS_EN
    drive(1'b0, 1'b0, $urandom, 1'($urandom), $urandom, IDLE_RESP);
    @(negedge CLK);
    checks++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL %s: hit_count=%0d miss_count=%0d, required hit_count=%0d miss_count=%0d",
               name, hit_count, miss_count, exp_hits, exp_misses);
    end
`else
    drive(1'b0, 1'b0, $urandom, 1'($urandom), $urandom, IDLE_RESP);
    if (name.len() == 0) $display("stats check skipped");
`endif
  endtask

  always @(negedge CLK) begin
    resp_t e;
    resp_t act;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      act = '{hit: ihit, load: imemload, ren: iREN, addr: iaddr};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL resp cycle %0d: ihit=%0b imemload=%h iREN=%0b iaddr=%h, required ihit=%0b imemload=%h iREN=%0b iaddr=%h",
                 cyc, act.hit, act.load, act.ren, act.addr, e.hit, e.load, e.ren, e.addr);
      end
    end
  end

  initial begin
    logic [31:0] a;
    m_clear();
    repeat (2) @(posedge CLK);
    // Reset state
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, IDLE_RESP);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, IDLE_RESP);

    // Cold miss, warm hit, stats
    access(32'h0000_0000, 2, 32'h2001_0004);
    access(32'h0000_0000, 0, 32'h0);
    check_stats("stats_cold_warm");

    // Conflict on index 0, then refetch of the evicted line
    access(32'h0000_0040, 1, 32'h8C22_0000);
    access(32'h0000_0000, 3, 32'h1234_5678);

    // Idle: cached address with no request
    drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0, IDLE_RESP);

    // Reset in the second FETCH cycle, coinciding with iwait=0
    drive(1'b0, 1'b1, 32'h0000_0044, 1'b1, 32'h0, IDLE_RESP);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, fetch_resp(32'h0000_0044));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, fetch_resp(32'h0000_0044));
    m_clear();
    drive(1'b0, 1'b0, 32'h0000_0044, 1'b0, 32'h0, IDLE_RESP);
    access(32'h0000_0000, 0, 32'hCAFE_0001);
    access(32'h0000_0044, 0, 32'hCAFE_0002);
    check_stats("stats_after_reset");

    // Randomized traffic over a few tags so hits, misses and conflicts all occur
    for (int t = 0; t < 300; t++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0)
        drive(1'b0, 1'b0, a, 1'($urandom), $urandom, IDLE_RESP);
      else
        access(a, $urandom_range(0, 4), $urandom);
    end
    check_stats("stats_random");

    repeat (3) @(negedge CLK);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
